// File: rtl/servo_sched_pkg.sv
// Shared types and constants for the servo frame scheduler.
package servo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GET_X,
        GET_Y,
        COMMIT
    } parse_state_e;

    typedef logic [6:0] pos_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hFF;
    localparam pos_t       CENTER_POS = 7'd64;

endpackage

// File: rtl/servo_slew_limiter.sv
// One axis: on step_en, move pos to target, but never by more than MAX_STEP per step.
// pos changes only on the edge ending a step_en cycle; no backpressure.
module servo_slew_limiter
    import servo_sched_pkg::*;
#(
    parameter int unsigned MAX_STEP = 4,
    parameter pos_t        CENTER   = CENTER_POS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_en,
    input  pos_t target,
    output pos_t pos
);

    localparam logic signed [7:0] STEP_S = 8'(MAX_STEP);
    localparam pos_t              STEP_P = 7'(MAX_STEP);

    pos_t              pos_q;
    pos_t              pos_d;
    logic signed [7:0] diff;

    // Both operands are 0..127, so an 8-bit signed difference cannot wrap.
    always_comb begin
        diff  = signed'({1'b0, target}) - signed'({1'b0, pos_q});
        pos_d = pos_q;
        if (step_en) begin
            if (diff > STEP_S) begin
                pos_d = pos_q + STEP_P;
            end else if (diff < -STEP_S) begin
                pos_d = pos_q - STEP_P;
            end else begin
                pos_d = target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q <= CENTER;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/servo_frame_scheduler.sv
// UART servo frame parser + per-PWM-period slew scheduler; WATCHDOG_EN adds a fail-safe return to CENTER.
// frame_ok one clk after the Y byte, positions move only after period_start; no backpressure, bytes never stalled.
module servo_frame_scheduler
    import servo_sched_pkg::*;
#(
    parameter int unsigned PERIOD_TICKS = 257,
    parameter int unsigned MAX_STEP     = 4,
    parameter pos_t        CENTER       = CENTER_POS,
    parameter int unsigned BYTE_TIMEOUT = 1024
`ifdef WATCHDOG_EN
    ,
    parameter int unsigned WDOG_PERIODS = 50
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [6:0] pos_x,
    output logic [6:0] pos_y,
    output logic       period_start,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       wdog_trip
);

    localparam int PW = $clog2(PERIOD_TICKS);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);

    logic [PW-1:0] per_cnt_q, per_cnt_d;
    parse_state_e  state_q, state_d;
    pos_t          x_q, x_d, y_q, y_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_d, frame_err_q;
    logic          in_frame;
    logic          commit;
    pos_t          tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;

    assign per_cnt_d    = (per_cnt_q == PW'(PERIOD_TICKS - 1)) ? '0 : per_cnt_q + PW'(1);
    assign period_start = (per_cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        err_d    = 1'b0;
        in_frame = (state_q == GET_X) || (state_q == GET_Y);
        case (state_q)
            // COMMIT consumes no byte, so a byte landing there is parsed as in IDLE.
            IDLE, COMMIT: begin
                state_d = IDLE;
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = GET_X;
                end
            end
            GET_X: begin
                if (rx_valid) begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = GET_X;
                    end else if (rx_data[7]) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        x_d     = rx_data[6:0];
                        state_d = GET_Y;
                    end
                end else if (tmo_q == TW'(BYTE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_Y: begin
                if (rx_valid) begin
                    if (rx_data == SYNC_BYTE) begin
                        err_d   = 1'b1;
                        state_d = GET_X;
                    end else if (rx_data[7]) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        y_d     = rx_data[6:0];
                        state_d = COMMIT;
                    end
                end else if (tmo_q == TW'(BYTE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tmo_d = (in_frame && !rx_valid && (state_d != IDLE)) ? tmo_q + TW'(1) : '0;
    end

    assign commit    = (state_q == COMMIT);
    assign frame_ok  = commit;
    assign frame_err = frame_err_q;

`ifdef WATCHDOG_EN
    localparam int WW = $clog2(WDOG_PERIODS + 1);

    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          trip_q, trip_d;

    // A frame commit in the trip cycle wins: it clears the count and loads its own targets.
    always_comb begin
        tgt_x_d  = tgt_x_q;
        tgt_y_d  = tgt_y_q;
        wd_cnt_d = wd_cnt_q;
        trip_d   = trip_q;
        if (commit) begin
            tgt_x_d  = x_q;
            tgt_y_d  = y_q;
            wd_cnt_d = '0;
            trip_d   = 1'b0;
        end else if (period_start && !trip_q) begin
            wd_cnt_d = wd_cnt_q + WW'(1);
            if (wd_cnt_q == WW'(WDOG_PERIODS - 1)) begin
                trip_d  = 1'b1;
                tgt_x_d = CENTER;
                tgt_y_d = CENTER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            trip_q   <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            trip_q   <= trip_d;
        end
    end

    assign wdog_trip = trip_q;
`else
    always_comb begin
        tgt_x_d = tgt_x_q;
        tgt_y_d = tgt_y_q;
        if (commit) begin
            tgt_x_d = x_q;
            tgt_y_d = y_q;
        end
    end

    assign wdog_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt_q   <= '0;
            state_q     <= IDLE;
            x_q         <= CENTER;
            y_q         <= CENTER;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            tgt_x_q     <= CENTER;
            tgt_y_q     <= CENTER;
        end else begin
            per_cnt_q   <= per_cnt_d;
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            tmo_q       <= tmo_d;
            frame_err_q <= err_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
        end
    end

    servo_slew_limiter #(
        .MAX_STEP (MAX_STEP),
        .CENTER   (CENTER)
    ) u_slew_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (period_start),
        .target  (tgt_x_q),
        .pos     (pos_x)
    );

    servo_slew_limiter #(
        .MAX_STEP (MAX_STEP),
        .CENTER   (CENTER)
    ) u_slew_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (period_start),
        .target  (tgt_y_q),
        .pos     (pos_y)
    );

endmodule
